// File: rtl/sub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sub_pkg
// Description : Shared types and constant helpers for the digit-serial
//               subtractor (FSM state encoding, counter sizing and
//               saturation bounds).
// Revision    : 1.0 - initial release
// ============================================================================
package sub_pkg;

    // Controller states; IDLE must stay at encoding 0 (reset state)
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Digit counter width: clog2 of the digit count, never below one bit
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Most positive two's-complement value of the given width (up to 64 bits)
    function automatic logic [63:0] sat_max(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    // Most negative two's-complement value of the given width (up to 64 bits)
    function automatic logic [63:0] sat_min(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sub_digit.sv
`default_nettype none
// ============================================================================
// Module      : sub_digit
// Description : Combinational DIGIT-bit subtract slice with borrow in/out.
//               Computes x - y - bin; bout is the borrow out of the slice.
// Revision    : 1.0 - initial release
// ============================================================================
module sub_digit
    import sub_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout
);

    // One extra bit catches the borrow: a negative result wraps and sets it
    logic [DIGIT:0] w_res;

    assign w_res = {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, bin};
    assign d     = w_res[DIGIT-1:0];
    assign bout  = w_res[DIGIT];

endmodule
`default_nettype wire

// File: rtl/sub_serial.sv
`default_nettype none
// ============================================================================
// Module      : sub_serial
// Description : Digit-serial subtractor computing a - b, least significant
//               digit first, WIDTH/DIGIT cycles per operation, with a
//               start/busy/done handshake, unsigned borrow and signed
//               overflow flags.
//               Optional build macro SUB_SERIAL_SAT_EN: saturate the result
//               on unsigned borrow / signed overflow (flags stay raw).
// Revision    : 1.0 - initial release
// ============================================================================
module sub_serial
    import sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int              N      = WIDTH / DIGIT;
    localparam int              CNT_W  = cnt_width(N);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(N - 1);

`ifdef SUB_SERIAL_SAT_EN
    localparam logic [WIDTH-1:0] c_SAT_MAX = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] c_SAT_MIN = WIDTH'(sat_min(WIDTH));
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               sm_q, sm_d;
    logic               bin_q, bin_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrow_q, borrow_d;
    logic               ovf_q, ovf_d;

    logic [DIGIT-1:0]   w_x;
    logic [DIGIT-1:0]   w_y;
    logic [DIGIT-1:0]   w_d;
    logic               w_bout;
    logic               w_ovf;

    // Select the current digit of each latched operand
    assign w_x = a_q[int'(cnt_q) * DIGIT +: DIGIT];
    assign w_y = b_q[int'(cnt_q) * DIGIT +: DIGIT];

    sub_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .x    (w_x),
        .y    (w_y),
        .bin  (bin_q),
        .d    (w_d),
        .bout (w_bout)
    );

    // Signed overflow: operand signs differ and result sign differs from a.
    // Only meaningful on the last digit, where w_d holds the result MSB.
    assign w_ovf = sm_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (w_d[DIGIT-1] ^ a_q[WIDTH-1]);

    // Next-state and datapath update for the IDLE/RUN/DONE controller
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        sm_d     = sm_q;
        bin_d    = bin_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    sm_d     = signed_mode;
                    diff_d   = '0;
                    borrow_d = 1'b0;
                    ovf_d    = 1'b0;
                    cnt_d    = '0;
                    bin_d    = 1'b0;
                    state_d  = ST_RUN;
                end
            end

            ST_RUN: begin
                diff_d[int'(cnt_q) * DIGIT +: DIGIT] = w_d;
                bin_d = w_bout;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == c_LAST) begin
                    borrow_d = w_bout;
                    ovf_d    = w_ovf;
`ifdef SUB_SERIAL_SAT_EN
                    // Clamp the result; the flags keep the raw condition
                    if (!sm_q && w_bout) begin
                        diff_d = '0;
                    end else if (w_ovf) begin
                        diff_d = a_q[WIDTH-1] ? c_SAT_MIN : c_SAT_MAX;
                    end
`endif
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sm_q     <= 1'b0;
            bin_q    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sm_q     <= sm_d;
            bin_q    <= bin_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign ovf    = ovf_q;
    assign busy   = (state_q == ST_RUN);
    assign done   = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: doc/sub_serial.md
# sub_serial

Parametrised digit-serial subtractor computing `a - b` over `WIDTH/DIGIT` clock cycles, least significant digit first, with a start/busy/done handshake. It reports the difference, an unsigned borrow and a signed overflow flag, and supports unsigned and signed modes. It supersedes the fixed 8-bit combinational `sub` block wherever area matters more than latency.

## Interface
- `WIDTH`, default 8: operand and result width. Must be a multiple of `DIGIT`.
- `DIGIT`, default 4: bits processed per cycle, 1 ≤ `DIGIT` ≤ `WIDTH`. `N = WIDTH/DIGIT` is the number of compute cycles.
- `clk`  in  1  clock. All state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request. Sampled only in IDLE.
- `signed_mode`  in  1  1 = two's-complement operands, 0 = unsigned. Latched with the operands.
- `a`  in  WIDTH  minuend. Latched on an accepted start.
- `b`  in  WIDTH  subtrahend. Latched on an accepted start.
- `diff`  out  WIDTH  result. Holds its value until the next accepted start.
- `borrow`  out  1  unsigned borrow out of the MSB (a < b as unsigned).
- `ovf`  out  1  signed overflow. Forced to 0 when `signed_mode`=0.
- `busy`  out  1  high in RUN.
- `done`  out  1  single-cycle pulse in DONE.

## Operation
- FSM states are IDLE, RUN and DONE. Reset state is IDLE.
- IDLE: if `start`=1, latch `a`, `b` and `signed_mode`, clear `diff`, `borrow` and `ovf`, set the digit counter to 0 and the internal borrow to 0, then go to RUN. Otherwise stay in IDLE.
- RUN, each cycle:
  - subtract digit `cnt` of a and b with the stored borrow-in;
  - write the DIGIT result bits into `diff[cnt*DIGIT +: DIGIT]`;
  - store the digit borrow-out;
  - increment `cnt`.
- RUN, last digit (`cnt`=N-1): also set `borrow` = final borrow-out, and `ovf` = `signed_mode` & (a[MSB] ≠ b[MSB]) & (diff[MSB] ≠ a[MSB]). Then go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE unconditionally.
- `start` in RUN or DONE is ignored. There is no queuing. A request must be re-issued once back in IDLE.
- Width rules:
  - `diff` = (a - b) mod 2^WIDTH, with no sign extension;
  - `cnt` width is clog2(N), minimum 1 bit;
  - the digit borrow is 1 bit.
- Operand inputs are don't-care outside the accepting cycle.
- Reset mid-operation aborts immediately. All outputs go to 0 and the FSM goes to IDLE. No partial result is retained.

## Timing
- Reset values: `diff`=0, `borrow`=0, `ovf`=0, `busy`=0, `done`=0, state=IDLE, `cnt`=0.
- Start accepted at edge E0: `busy` rises after E0. Digits are processed at edges E1…EN.
- After EN: `busy`=0, `done`=1, and `diff`, `borrow` and `ovf` are final. After EN+1: `done`=0.
- Latency is N+1 edges from the accepting edge to `done` high. Throughput is one operation per N+2 cycles.
- Back-to-back operation: `start` held high is next accepted at edge EN+2 (first IDLE cycle).
- `N`=1 (DIGIT=WIDTH): RUN lasts one cycle.

## Configuration
- Macro `SUB_SERIAL_SAT_EN`.
- Defined, saturation is applied when entering DONE:
  - unsigned mode with `borrow`=1: `diff` = 0;
  - signed mode with `ovf`=1: `diff` = most positive value (0111…1) if a[MSB]=0, or most negative (1000…0) if a[MSB]=1.
  - Flags still report the raw condition.
- Undefined: `diff` wraps modulo 2^WIDTH. Flags are unchanged.
- Timing is identical in both builds.

## Structure
- Package `sub_pkg` holds:
  - the FSM state enum (IDLE, RUN, DONE);
  - a clog2-based counter-width helper;
  - saturation constant functions (max/min for a given WIDTH).
- Sub-module `sub_digit`: combinational DIGIT-bit subtract slice. Inputs are `x`, `y` and `bin`; outputs are `d` and `bout`. It is instantiated once, and the top level muxes digits into it by `cnt`.

## Test plan
All scenarios use WIDTH=8, DIGIT=4, N=2 unless stated.
- Unsigned 0x0B - 0x08: `done` 3 edges after start. `diff`=0x03, `borrow`=0, `ovf`=0, `busy` high for exactly 2 cycles.
- Unsigned 0x03 - 0x08: `diff`=0xFB, `borrow`=1. With `SUB_SERIAL_SAT_EN`: `diff`=0x00, `borrow`=1.
- Signed 0x80 - 0x01: `diff`=0x7F, `ovf`=1. With `SUB_SERIAL_SAT_EN`: `diff`=0x80. Also signed 0x7F - 0xFF: `diff`=0x80, `ovf`=1, saturated result 0x7F.
- `start` pulsed in RUN with new operands: ignored. First result unchanged, only one `done` pulse. `start` held high: the second operation begins on the first IDLE cycle.
- `rst` asserted asynchronously mid-RUN: all outputs 0 immediately. After release, a new operation 0x0F - 0x01 completes with `diff`=0x0E.
- WIDTH=8, DIGIT=1, 0xFF - 0x01: `done` 9 edges after start, `diff`=0xFE. Also WIDTH=16, DIGIT=16, 0x0000 - 0x0001: `diff`=0xFFFF, `borrow`=1, `done` 2 edges after start.
